// File: rtl/vram_sync_pkg.sv
// rtl/vram_sync_pkg.sv - shared types and derived sizes for the VRAM vblank sync scheduler.
package vram_sync_pkg;

  localparam int VS_ADDR_W = 13;
  localparam int VS_BLK_W  = 5;
  localparam int NUM_BLK   = 1 << (VS_ADDR_W - VS_BLK_W);
  localparam int BLK_WORDS = 1 << VS_BLK_W;

  typedef logic [VS_ADDR_W-VS_BLK_W-1:0] blk_idx_t;

  typedef enum logic [2:0] {IDLE, SCAN, COPY, DRAIN, DONE} state_t;

endpackage

// File: rtl/vram_dirty_map.sv
// rtl/vram_dirty_map.sv - per-block dirty bits; snoop set beats scheduler clear.
module vram_dirty_map #(
  parameter int NB_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en_i,
  input  logic [NB_W-1:0] set_idx_i,
  input  logic            clr_en_i,
  input  logic [NB_W-1:0] clr_idx_i,
  input  logic [NB_W-1:0] rd_idx_i,
  output logic            rd_bit_o
);

  localparam int NBLK = 1 << NB_W;

  logic [NBLK-1:0] dirty_q;

  // Set is written last so it wins a same-cycle collision with clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q <= '1;
    end else begin
      if (clr_en_i) dirty_q[clr_idx_i] <= 1'b0;
      if (set_en_i) dirty_q[set_idx_i] <= 1'b1;
    end
  end

  assign rd_bit_o = dirty_q[rd_idx_i];

endmodule

// File: rtl/vram_sync_sched.sv
// rtl/vram_sync_sched.sv - vblank copy of dirty VRAM blocks from CPU side to PPU side.
// Dirty tracking only with VRAM_SYNC_DIRTY_TRACK_EN; otherwise every sync copies everything.
module vram_sync_sched
  import vram_sync_pkg::*;
#(
  parameter int ADDR_W = VS_ADDR_W,
  parameter int DATA_W = 64,
  parameter int BLK_W  = VS_BLK_W,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sync_start,
  output logic                sync_busy,
  output logic                sync_done,
  input  logic [ADDR_W-1:0]   cpu_wraddr,
  input  logic                cpu_wren,
  output logic                rdC_en,
  output logic [ADDR_W-1:0]   rdC_addr,
  input  logic [DATA_W-1:0]   rdC_data,
  output logic                wrP_en,
  output logic [ADDR_W-1:0]   wrP_addr,
  output logic [DATA_W-1:0]   wrP_data,
  output logic [DATA_W/8-1:0] wrP_byteena,
  output logic [ADDR_W:0]     words_copied
);

  localparam int NB_W  = ADDR_W - BLK_W;
  localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [NB_W-1:0]   blk_q, blk_d;
  logic [BLK_W-1:0]  off_q, off_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              rd_en, clr_en, blk_dirty;
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] adr_q [RD_LAT];
  logic              unused_bits;

`ifdef VRAM_SYNC_DIRTY_TRACK_EN
  vram_dirty_map #(.NB_W(NB_W)) u_dirty (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (cpu_wren),
    .set_idx_i (cpu_wraddr[ADDR_W-1:BLK_W]),
    .clr_en_i  (clr_en),
    .clr_idx_i (blk_q),
    .rd_idx_i  (blk_q),
    .rd_bit_o  (blk_dirty)
  );
`else
  assign blk_dirty = 1'b1;
`endif

  assign unused_bits = ^{cpu_wren, cpu_wraddr, clr_en};

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    off_d   = off_q;
    drn_d   = drn_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    rd_en   = 1'b0;
    clr_en  = 1'b0;
    if (wrP_en && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    case (state_q)
      IDLE: if (sync_start) begin
        state_d = SCAN;
        blk_d   = '0;
        cnt_d   = '0;
      end
      SCAN: begin
        if (blk_dirty) begin
          clr_en  = 1'b1;
          off_d   = '0;
          state_d = COPY;
        end else if (blk_q == {NB_W{1'b1}}) begin
          drn_d   = '0;
          state_d = DRAIN;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      COPY: begin
        rd_en = 1'b1;
        off_d = off_q + 1'b1;
        if (off_q == {BLK_W{1'b1}}) begin
          if (blk_q == {NB_W{1'b1}}) begin
            drn_d   = '0;
            state_d = DRAIN;
          end else begin
            blk_d   = blk_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_W'(RD_LAT - 1)) state_d = DONE;
      end
      DONE: begin
        wc_d    = cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      off_q   <= '0;
      drn_q   <= '0;
      cnt_q   <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      off_q   <= off_d;
      drn_q   <= drn_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
    end
  end

  // Address/valid delay line matching the C-side read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) adr_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_en;
      adr_q[0] <= rdC_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

  assign sync_busy    = (state_q != IDLE);
  assign sync_done    = (state_q == DONE);
  assign rdC_en       = rd_en;
  assign rdC_addr     = rd_en ? {blk_q, off_q} : '0;
  assign wrP_en       = vld_q[RD_LAT-1];
  assign wrP_addr     = adr_q[RD_LAT-1];
  assign wrP_data     = wrP_en ? rdC_data : '0;
  assign wrP_byteena  = {(DATA_W/8){wrP_en}};
  assign words_copied = wc_q;

endmodule

// File: tb/tb_vram_sync_sched.sv
// tb/tb_vram_sync_sched.sv - scoreboard bench for vram_sync_sched, both dirty-tracking builds.
module tb_vram_sync_sched;

  localparam int RD_LAT = 2;
  localparam int FULL   = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_start;
  logic        sync_busy;
  logic        sync_done;
  logic [12:0] cpu_wraddr;
  logic        cpu_wren;
  logic        rdC_en;
  logic [12:0] rdC_addr;
  logic [63:0] rdC_data;
  logic        wrP_en;
  logic [12:0] wrP_addr;
  logic [63:0] wrP_data;
  logic [7:0]  wrP_byteena;
  logic [13:0] words_copied;

  vram_sync_sched #(.ADDR_W(13), .DATA_W(64), .BLK_W(5), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .sync_start(sync_start), .sync_busy(sync_busy),
    .sync_done(sync_done), .cpu_wraddr(cpu_wraddr), .cpu_wren(cpu_wren),
    .rdC_en(rdC_en), .rdC_addr(rdC_addr), .rdC_data(rdC_data),
    .wrP_en(wrP_en), .wrP_addr(wrP_addr), .wrP_data(wrP_data),
    .wrP_byteena(wrP_byteena), .words_copied(words_copied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pre_wr;
    logic [12:0] pre_addr;
    int          mid_cyc;
    logic [12:0] mid_addr;
    int          rs_cyc;
    int          exp_words;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [12:0] exp_q [$];
  logic        dirty_m [256];
  logic [12:0] m_adr [RD_LAT];
  vec_t        tbl [8];

  function automatic logic [63:0] cdat(input logic [12:0] a);
    return {a, 3'b101, ~a, 3'b010, 32'(a) * 32'h9E37_79B1};
  endfunction

  function automatic int ew(input int w);
`ifdef VRAM_SYNC_DIRTY_TRACK_EN
    return w;
`else
    return FULL;
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // C-side VRAM model: data is a fixed function of the address, RD_LAT cycles late.
  always @(posedge clk) begin
    m_adr[0] <= rdC_addr;
    for (int i = 1; i < RD_LAT; i++) m_adr[i] <= m_adr[i-1];
  end
  assign rdC_data = cdat(m_adr[RD_LAT-1]);

  always @(negedge clk) begin
    if (sync_done) done_cnt++;
    if (wrP_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {1'b1, wrP_addr}, 14'h0);
      end else begin
        automatic logic [12:0] a = exp_q.pop_front();
        chk("write", {wrP_addr, wrP_byteena, wrP_data}, {a, 8'hFF, cdat(a)});
      end
    end
  end

  task automatic push_dirty();
    for (int b = 0; b < 256; b++) begin
      if (dirty_m[b]) begin
        for (int o = 0; o < 32; o++) exp_q.push_back(13'(b * 32 + o));
`ifdef VRAM_SYNC_DIRTY_TRACK_EN
        dirty_m[b] = 1'b0;
`endif
      end
    end
  endtask

  task automatic run_sync(input vec_t v);
    int k;
    int dc0;
    if (v.pre_wr) begin
      cpu_wraddr = v.pre_addr;
      cpu_wren   = 1'b1;
      @(negedge clk);
      cpu_wren   = 1'b0;
`ifdef VRAM_SYNC_DIRTY_TRACK_EN
      dirty_m[v.pre_addr[12:5]] = 1'b1;
`endif
    end
    push_dirty();
`ifdef VRAM_SYNC_DIRTY_TRACK_EN
    if (v.mid_cyc != 0) dirty_m[v.mid_addr[12:5]] = 1'b1;
`endif
    dc0 = done_cnt;
    sync_start = 1'b1;
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      sync_start = (k == v.rs_cyc);
      cpu_wren   = (k == v.mid_cyc);
      cpu_wraddr = v.mid_addr;
      if (sync_done) break;
      if (k > 12000) begin
        chk("sync_timeout", k, 0);
        break;
      end
    end
    sync_start = 1'b0;
    cpu_wren   = 1'b0;
    chk("sync_cycles", k, 257 + v.exp_words + RD_LAT);
    @(negedge clk);
    chk("words_copied", words_copied, v.exp_words);
    chk("busy_after_done", sync_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - dc0, 1);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int k;
    int dc0;
    for (int b = 0; b < 256; b++) dirty_m[b] = 1'b1;
    tbl[0] = '{1'b0, 13'h0000, 0, 13'h0000, 0,   FULL};
    tbl[1] = '{1'b0, 13'h0000, 0, 13'h0000, 0,   ew(0)};
    tbl[2] = '{1'b1, 13'h0045, 0, 13'h0000, 0,   ew(32)};
    tbl[3] = '{1'b0, 13'h0000, 0, 13'h0000, 0,   ew(0)};
    tbl[4] = '{1'b1, 13'h00E3, 8, 13'h00E3, 0,   ew(32)};
    tbl[5] = '{1'b0, 13'h0000, 0, 13'h0000, 0,   ew(32)};
    tbl[6] = '{1'b1, 13'h1FFF, 0, 13'h0000, 260, ew(32)};
    tbl[7] = '{1'b0, 13'h0000, 0, 13'h0000, 0,   ew(0)};

    rst = 1'b1;
    sync_start = 1'b0;
    cpu_wren = 1'b0;
    cpu_wraddr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sync_busy, sync_done, rdC_en, rdC_addr, wrP_en, wrP_addr,
                          wrP_data, wrP_byteena, words_copied}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {sync_busy, sync_done, rdC_en, wrP_en, words_copied}, '0);

    for (int i = 0; i < 8; i++) run_sync(tbl[i]);

    // Reset in the middle of copying block 0.
    cpu_wraddr = 13'h0003;
    cpu_wren   = 1'b1;
    @(negedge clk);
    cpu_wren   = 1'b0;
    for (int o = 0; o < 32; o++) exp_q.push_back(13'(o));
    dc0 = done_cnt;
    sync_start = 1'b1;
    k = 0;
    while (k < 11) begin
      @(negedge clk);
      k++;
      sync_start = 1'b0;
      if (k == 10) rst = 1'b1;
    end
    chk("mid_reset_outputs", {sync_busy, sync_done, rdC_en, rdC_addr, wrP_en, wrP_addr,
                              wrP_data, wrP_byteena, words_copied}, '0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("no_done_on_reset", done_cnt - dc0, 0);
    for (int b = 0; b < 256; b++) dirty_m[b] = 1'b1;
    run_sync('{1'b0, 13'h0000, 0, 13'h0000, 0, FULL});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_sync_sched.md
Name: vram_sync_sched

Overview:
- Scheduler that copies the CPU-facing VRAM into the PPU-facing VRAM during vblank.
- Copies only blocks the CPU has written since the last sync. Clean blocks are skipped, so the sync finishes well inside vblank.
- Sits behind vram_interconnect in the vram_sync_writer slot. Started by the PPU FSM's one-cycle sync pulse.
- Snoops CPU writes to keep a per-block dirty map.

Parameters:
- ADDR_W, 13, VRAM word address width.
- DATA_W, 64, VRAM word width.
- BLK_W, 5, log2 of words per block (32 words per block, 256 blocks).
- RD_LAT, 2, CPU-facing VRAM read latency in cycles, at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sync_start  in  1  one-cycle pulse that starts a sync.
- sync_busy  out  1  high while a sync is in progress.
- sync_done  out  1  one-cycle pulse when the sync is complete.
- cpu_wraddr  in  ADDR_W  snooped CPU write address.
- cpu_wren  in  1  snooped CPU write enable.
- rdC_en  out  1  CPU-facing VRAM read enable.
- rdC_addr  out  ADDR_W  CPU-facing VRAM read address.
- rdC_data  in  DATA_W  read data, valid RD_LAT cycles after rdC_en.
- wrP_en  out  1  PPU-facing VRAM write enable.
- wrP_addr  out  ADDR_W  PPU-facing VRAM write address.
- wrP_data  out  DATA_W  PPU-facing VRAM write data.
- wrP_byteena  out  DATA_W/8  byte enables, all ones whenever wrP_en=1.
- words_copied  out  ADDR_W+1  words written by the last completed sync.

Behaviour:
- Reset:
  - All outputs 0; words_copied=0; state IDLE.
  - Every dirty bit is set, so the first sync after reset is a full copy.
  - Reset mid-operation aborts the sync immediately. No sync_done pulse.
- IDLE:
  - sync_start=1 -> SCAN next cycle; block pointer b=0; copy counter=0.
- SCAN (one cycle per block):
  - Test dirty[b].
  - If dirty: go to COPY and clear dirty[b] this cycle.
  - If clean and b is the last block: go to DRAIN. Otherwise b=b+1 and stay in SCAN.
- COPY:
  - Issue rdC_en with rdC_addr = {b, offset}, offset 0..2^BLK_W-1, one read per cycle.
  - After the last offset: if b is the last block go to DRAIN, else b=b+1 and go to SCAN.
- Write pipeline:
  - The address and valid bit are delayed RD_LAT cycles.
  - wrP_en, wrP_addr and wrP_data=rdC_data are asserted exactly RD_LAT cycles after the matching rdC_en.
  - Throughput is 1 word per cycle. Writes stay in order.
  - The copy counter increments on each wrP_en.
- DRAIN:
  - Hold for RD_LAT cycles so in-flight writes complete, then go to DONE.
- DONE:
  - sync_done=1 for one cycle.
  - words_copied is loaded from the copy counter.
  - Then return to IDLE.
- sync_busy is 1 in SCAN, COPY, DRAIN and DONE.
- Timing example: with no dirty blocks and sync_start at cycle 0, SCAN runs cycles 1..256, DRAIN runs 257..256+RD_LAT, and sync_done is at cycle 257+RD_LAT.
- Dirty marking:
  - cpu_wren=1 sets dirty[cpu_wraddr[ADDR_W-1:BLK_W]] in every state.
  - A set and a clear of the same bit in the same cycle: set wins.
- sync_start while sync_busy=1 is ignored; it is not queued.
- The block pointer never wraps within a sync.
- words_copied saturates at 2^ADDR_W, which is also its natural maximum.

Optional Feature:
- Macro: VRAM_SYNC_DIRTY_TRACK_EN.
- Defined: dirty-map behaviour exactly as above.
- Undefined:
  - No dirty map is instantiated.
  - Every block is treated as dirty and cpu_wraddr/cpu_wren are ignored.
  - Every sync copies all 2^ADDR_W words.
  - Total cycles from sync_start to sync_done = 256*(1+32)+RD_LAT+1.

Decomposition:
- Package vram_sync_pkg holds:
  - the state enum (IDLE, SCAN, COPY, DRAIN, DONE);
  - derived localparams: NUM_BLK = 2^(ADDR_W-BLK_W), BLK_WORDS = 2^BLK_W;
  - the block-index typedef.
- Sub-module vram_dirty_map:
  - NUM_BLK-bit register with a set port (snoop) and a clear port (scheduler); set has priority.
  - Combinational read of one bit.
  - Reset sets all bits.
  - Not instantiated when VRAM_SYNC_DIRTY_TRACK_EN is undefined.

Test Plan:
- Reset, then sync_start: all 8192 words are copied in address order. wrP_data matches the C-side model for every address; words_copied=8192; sync_done is pulsed once.
- Second sync with no CPU writes in between: no wrP_en at all. sync_done is at cycle 257+RD_LAT (259 with RD_LAT=2); words_copied=0.
- CPU write to 0x0045, then sync: exactly addresses 0x0040..0x005F are written; words_copied=32. A following sync copies 0.
- cpu_wren to block 7 in the same cycle SCAN clears dirty[7]: block 7 is copied now and again on the next sync (32 words).
- sync_start pulsed again during COPY: ignored. There is a single sync_done and no restart.
- rst asserted mid-COPY: all outputs are 0 on the next cycle with no sync_done. The next sync copies 8192 words.
